// File: rtl/div_error_monitor.sv
// rtl/div_error_monitor.sv - exact-division error monitor for an approximate 16/8 divider
//
// Recomputes each accepted sample with an 8-iteration restoring divider and
// accumulates quotient-error statistics against the approximate divider output.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clear             synchronous clear of all statistics (wins over updates)
//   in_valid/in_ready sample handshake; in_ready is high only in IDLE
//   n, d              dividend / divisor presented to the divider
//   q_apx, r_apx      approximate quotient / remainder from the divider
//   res_valid         one-cycle pulse after each processed sample
//   q_exact, r_exact  exact quotient / remainder of the last processed sample
//   q_err             signed q_apx - q_exact (9-bit two's complement)
//   sum_sq_err        saturating sum of q_err squared
//   sample_cnt        processed samples (saturating)
//   mismatch_cnt      samples with q or r mismatch (saturating)
//   skip_cnt          rejected samples (saturating)
//   max_abs_err       largest |q_err| since clear
//   sat               sticky saturation flag

module div_error_monitor #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      n,
    input  logic [7:0]       d,
    input  logic [7:0]       q_apx,
    input  logic [7:0]       r_apx,
    output logic             res_valid,
    output logic [7:0]       q_exact,
    output logic [7:0]       r_exact,
    output logic [8:0]       q_err,
    output logic [ACC_W-1:0] sum_sq_err,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [7:0]       max_abs_err,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ACCUM = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0] r_d;
    logic [7:0] r_nlo;
    logic [7:0] r_qa;
    logic [7:0] r_ra;
    logic [8:0] r_pr;
    logic [7:0] r_q;
    logic [2:0] r_iter;

    logic         w_skip;
    logic         w_accept;
    logic [8:0]   w_shift;
    logic         w_ge;
    logic [8:0]   w_sub;
    logic [8:0]   w_err;
    logic [8:0]   w_neg;
    logic [7:0]   w_abs;
    logic [15:0]  w_sq;
    logic [ACC_W:0] w_sum_ext;
    logic         w_mis;

    // Quotient would overflow 8 bits whenever the high dividend byte reaches d.
    assign w_skip   = (d == 8'd0) || (n[15:8] >= d);
    assign w_accept = (r_state == S_IDLE) && in_valid;

    // Partial remainder stays below d, so bit 8 of r_pr is always zero here.
    assign w_shift = {r_pr[7:0], r_nlo[7]};
    assign w_ge    = (w_shift >= {1'b0, r_d});
    assign w_sub   = w_shift - {1'b0, r_d};

    assign w_err     = {1'b0, r_qa} - {1'b0, r_q};
    assign w_neg     = 9'd0 - w_err;
    assign w_abs     = w_err[8] ? w_neg[7:0] : w_err[7:0];
    assign w_sq      = {8'd0, w_abs} * {8'd0, w_abs};
    assign w_sum_ext = {1'b0, sum_sq_err} + {{(ACC_W-15){1'b0}}, w_sq};
    assign w_mis     = (r_qa != r_q) || (r_ra != r_pr[7:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !w_skip) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_iter == 3'd7) begin
                    w_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture and restoring-division iterations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d    <= 8'd0;
            r_nlo  <= 8'd0;
            r_qa   <= 8'd0;
            r_ra   <= 8'd0;
            r_pr   <= 9'd0;
            r_q    <= 8'd0;
            r_iter <= 3'd0;
        end else if (w_accept && !w_skip) begin
            r_d    <= d;
            r_nlo  <= n[7:0];
            r_qa   <= q_apx;
            r_ra   <= r_apx;
            r_pr   <= {1'b0, n[15:8]};
            r_q    <= 8'd0;
            r_iter <= 3'd0;
        end else if (r_state == S_CALC) begin
            r_pr   <= w_ge ? w_sub : w_shift;
            r_q    <= {r_q[6:0], w_ge};
            r_nlo  <= {r_nlo[6:0], 1'b0};
            r_iter <= r_iter + 3'd1;
        end
    end

    // Per-sample results are produced even when clear wipes the statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            q_exact   <= 8'd0;
            r_exact   <= 8'd0;
            q_err     <= 9'd0;
        end else begin
            res_valid <= (r_state == S_ACCUM);
            if (r_state == S_ACCUM) begin
                q_exact <= r_q;
                r_exact <= r_pr[7:0];
                q_err   <= w_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_sq_err   <= '0;
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            skip_cnt     <= '0;
            max_abs_err  <= 8'd0;
            sat          <= 1'b0;
        end else if (clear) begin
            sum_sq_err   <= '0;
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            skip_cnt     <= '0;
            max_abs_err  <= 8'd0;
            sat          <= 1'b0;
        end else if (w_accept && w_skip) begin
            if (&skip_cnt) begin
                sat <= 1'b1;
            end else begin
                skip_cnt <= skip_cnt + CNT_ONE;
            end
        end else if (r_state == S_ACCUM) begin
            if (w_sum_ext[ACC_W]) begin
                sum_sq_err <= '1;
                sat        <= 1'b1;
            end else begin
                sum_sq_err <= w_sum_ext[ACC_W-1:0];
            end
            if (&sample_cnt) begin
                sat <= 1'b1;
            end else begin
                sample_cnt <= sample_cnt + CNT_ONE;
            end
            if (w_mis) begin
                if (&mismatch_cnt) begin
                    sat <= 1'b1;
                end else begin
                    mismatch_cnt <= mismatch_cnt + CNT_ONE;
                end
            end
            if (w_abs > max_abs_err) begin
                max_abs_err <= w_abs;
            end
        end
    end

endmodule

// File: tb/tb_div_error_monitor.sv
// tb/tb_div_error_monitor.sv - self-checking bench for div_error_monitor

module tb_div_error_monitor;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  q_apx;
    logic [7:0]  r_apx;
    logic        res_valid;
    logic [7:0]  q_exact;
    logic [7:0]  r_exact;
    logic [8:0]  q_err;
    logic [31:0] sum_sq_err;
    logic [15:0] sample_cnt;
    logic [15:0] mismatch_cnt;
    logic [15:0] skip_cnt;
    logic [7:0]  max_abs_err;
    logic        sat;

    logic        in_ready17;
    logic        res_valid17;
    logic [7:0]  q_exact17;
    logic [7:0]  r_exact17;
    logic [8:0]  q_err17;
    logic [16:0] sum_sq_err17;
    logic [15:0] sample_cnt17;
    logic [15:0] mismatch_cnt17;
    logic [15:0] skip_cnt17;
    logic [7:0]  max_abs_err17;
    logic        sat17;

    div_error_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx),
        .res_valid(res_valid), .q_exact(q_exact), .r_exact(r_exact),
        .q_err(q_err), .sum_sq_err(sum_sq_err), .sample_cnt(sample_cnt),
        .mismatch_cnt(mismatch_cnt), .skip_cnt(skip_cnt),
        .max_abs_err(max_abs_err), .sat(sat)
    );

    div_error_monitor #(.ACC_W(17), .CNT_W(16)) u_dut17 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready17),
        .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx),
        .res_valid(res_valid17), .q_exact(q_exact17), .r_exact(r_exact17),
        .q_err(q_err17), .sum_sq_err(sum_sq_err17), .sample_cnt(sample_cnt17),
        .mismatch_cnt(mismatch_cnt17), .skip_cnt(skip_cnt17),
        .max_abs_err(max_abs_err17), .sat(sat17)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: integer division plus plain bookkeeping of statistics.
    localparam longint MAX32 = 64'd4294967295;
    localparam longint MAX17 = 64'd131071;

    int     m_busy = 0;
    int     m_n = 0, m_d = 1, m_qa = 0, m_ra = 0;
    int     e_res = 0, e_q = 0, e_r = 0, e_err = 0;
    longint e_sum = 0, e_sum17 = 0;
    int     e_cnt = 0, e_mis = 0, e_skip = 0, e_max = 0;
    int     e_sat = 0, e_sat17 = 0;
    int     qx, rx, er, ab;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            e_res = 0; e_q = 0; e_r = 0; e_err = 0;
            e_sum = 0; e_sum17 = 0; e_cnt = 0; e_mis = 0; e_skip = 0;
            e_max = 0; e_sat = 0; e_sat17 = 0;
        end else begin
            e_res = 0;
            if (m_busy > 0) begin
                m_busy = m_busy - 1;
                if (m_busy == 0) begin
                    qx = m_n / m_d;
                    rx = m_n % m_d;
                    er = m_qa - qx;
                    ab = (er < 0) ? -er : er;
                    e_q = qx; e_r = rx; e_err = er & 511; e_res = 1;
                    e_sum = e_sum + ab * ab;
                    if (e_sum > MAX32) begin e_sum = MAX32; e_sat = 1; end
                    e_sum17 = e_sum17 + ab * ab;
                    if (e_sum17 > MAX17) begin e_sum17 = MAX17; e_sat17 = 1; end
                    if (e_cnt == 65535) begin e_sat = 1; e_sat17 = 1; end
                    else e_cnt++;
                    if (m_qa != qx || m_ra != rx) begin
                        if (e_mis == 65535) begin e_sat = 1; e_sat17 = 1; end
                        else e_mis++;
                    end
                    if (ab > e_max) e_max = ab;
                end
            end else if (in_valid) begin
                if (int'(d) == 0 || int'(n) / 256 >= int'(d)) begin
                    if (e_skip == 65535) begin e_sat = 1; e_sat17 = 1; end
                    else e_skip++;
                end else begin
                    m_busy = 9;
                    m_n = int'(n); m_d = int'(d); m_qa = int'(q_apx); m_ra = int'(r_apx);
                end
            end
            if (clear) begin
                e_sum = 0; e_sum17 = 0; e_cnt = 0; e_mis = 0; e_skip = 0;
                e_max = 0; e_sat = 0; e_sat17 = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready",     in_ready,     (m_busy == 0) ? 1 : 0);
        chk("res_valid",    res_valid,    e_res);
        chk("q_exact",      q_exact,      e_q);
        chk("r_exact",      r_exact,      e_r);
        chk("q_err",        q_err,        e_err);
        chk("sum_sq_err",   sum_sq_err,   e_sum);
        chk("sample_cnt",   sample_cnt,   e_cnt);
        chk("mismatch_cnt", mismatch_cnt, e_mis);
        chk("skip_cnt",     skip_cnt,     e_skip);
        chk("max_abs_err",  max_abs_err,  e_max);
        chk("sat",          sat,          e_sat);
        chk("sum17",        sum_sq_err17, e_sum17);
        chk("sat17",        sat17,        e_sat17);
        chk("res_valid17",  res_valid17,  e_res);
    end

    task automatic send(input logic [15:0] nn, input logic [7:0] dd,
                        input logic [7:0] qa, input logic [7:0] ra);
        n = nn; d = dd; q_apx = qa; r_apx = ra; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble the operands to show they are only sampled on acceptance.
        n = ~nn; d = ~dd; q_apx = ~qa; r_apx = ~ra;
    endtask

    task automatic wait_res(output int lat);
        bit found = 1'b0;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (res_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_total++;
            $display("FAIL res_timeout: no res_valid within %0d cycles", lat);
        end
    endtask

    int lat;

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        n = 16'd0; d = 8'd0; q_apx = 8'd0; r_apx = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_sum", sum_sq_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(16'd1000, 8'd10, 8'd100, 8'd0);
        wait_res(lat);
        chk("t1_latency", lat, 9);
        chk("t1_q_exact", q_exact, 100);
        chk("t1_r_exact", r_exact, 0);
        chk("t1_q_err", q_err, 0);
        chk("t1_sample_cnt", sample_cnt, 1);
        chk("t1_mismatch", mismatch_cnt, 0);
        chk("t1_sum", sum_sq_err, 0);

        send(16'd1000, 8'd10, 8'd98, 8'd20);
        wait_res(lat);
        chk("t2_latency", lat, 9);
        chk("t2_q_err", q_err, 9'h1FE);
        chk("t2_sum", sum_sq_err, 4);
        chk("t2_mismatch", mismatch_cnt, 1);
        chk("t2_max_abs", max_abs_err, 2);
        chk("t2_sample_cnt", sample_cnt, 2);

        send(16'h1234, 8'd0, 8'd0, 8'd0);
        chk("skip_in_ready", in_ready, 1);
        send(16'h0A00, 8'd10, 8'd0, 8'd0);
        repeat (12) @(negedge clk);
        chk("skip_cnt", skip_cnt, 2);
        chk("skip_sample_cnt", sample_cnt, 2);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        send(16'd5, 8'd200, 8'd255, 8'd5);
        wait_res(lat);
        chk("s1_sum17", sum_sq_err17, 65025);
        chk("s1_r_exact", r_exact, 5);
        send(16'd5, 8'd200, 8'd255, 8'd5);
        wait_res(lat);
        chk("s2_sum17", sum_sq_err17, 130050);
        chk("s2_sat17", sat17, 0);
        send(16'd5, 8'd200, 8'd255, 8'd5);
        wait_res(lat);
        chk("s3_sum17", sum_sq_err17, 131071);
        chk("s3_sat17", sat17, 1);
        chk("s3_sum32", sum_sq_err, 195075);
        chk("s3_sat32", sat, 0);

        send(16'hFEFF, 8'hFF, 8'hFF, 8'hFE);
        wait_res(lat);
        chk("max_q_exact", q_exact, 255);
        chk("max_r_exact", r_exact, 254);

        send(16'd1000, 8'd10, 8'd90, 8'd0);
        repeat (8) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_res_valid", res_valid, 1);
        chk("clr_q_exact", q_exact, 100);
        chk("clr_q_err", q_err, 9'h1F6);
        chk("clr_sum", sum_sq_err, 0);
        chk("clr_sample_cnt", sample_cnt, 0);
        chk("clr_max_abs", max_abs_err, 0);
        chk("clr_sat17", sat17, 0);

        send(16'd1000, 8'd10, 8'd100, 8'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_q_exact", q_exact, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        send(16'hFFFF, 8'hFF, 8'd0, 8'd0);
        @(negedge clk);
        chk("post_rst_skip", skip_cnt, 1);
        chk("post_rst_sample", sample_cnt, 0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
